mux_data_source_pipe: RTL and testbench

Parametrised, registered successor to the register-file write-back data-source selector. It picks one of `N_SRC` `DATA_W`-bit datapath sources, such as ALUOut, HI/LO, shifter, LT, sign-extend, shift-left-16 and regA/regB. The selected word is presented through a one-cycle pipeline stage with a valid/ready handshake and a 2-entry skid buffer. Out-of-range selects are detected and flagged with a sticky error bit, instead of silently holding stale data. It sits between the datapath sources and the register-file write port, and the control unit drives the select and valid strobes.

---
 rtl/mux_data_source_pipe.sv | 191 +++++++++++++++++++
 tb/tb_mux_data_source_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_data_source_pipe.sv
// ---------------------------------------------------------------------------
// mux_data_source_pipe
//
// Registered write-back data-source selector. One of N_SRC datapath words
// (ALUOut, HI/LO, shifter, LT, sign-extend, shift-left-16, regA/regB, ...)
// is picked by `sel`, captured on a valid/ready accept and presented through
// a single pipeline stage backed by a 2-entry skid buffer (main + skid).
// Out-of-range selects are captured with substitute data and raise a
// sticky error flag.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   src_flat   packed sources, source k at [k*DATA_W +: DATA_W]
//   sel        source select, sampled on accept
//   in_valid   producer offers src_flat[sel] this cycle
//   in_ready   block can accept this cycle (low only while skid is full)
//   out_data   selected word (main entry)
//   out_sel    raw select that produced out_data
//   out_valid  out_data/out_sel hold a valid word
//   out_ready  consumer takes the word this cycle
//   flush      synchronous discard of both entries
//   err_clr    synchronous clear of sel_err
//   sel_err    sticky: an out-of-range select was accepted
// ---------------------------------------------------------------------------
module mux_data_source_pipe #(
  parameter int DATA_W   = 32,
  parameter int N_SRC    = 10,
  parameter int OOR_ZERO = 1,
  localparam int SEL_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC*DATA_W-1:0] src_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic                    sel_err
);

  // The state encoding is the pair of entry valid bits: bit 0 = main valid,
  // bit 1 = skid valid. The skid entry is never valid without main.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]    main_sel_q,  main_sel_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]    skid_sel_q,  skid_sel_d;
  logic [DATA_W-1:0]   last_q,      last_d;
  logic                err_q,       err_d;

  logic                accept;
  logic                deliver;
  logic                sel_in_range;
  logic [DATA_W-1:0]   sel_word;
  logic [DATA_W-1:0]   cap_data;

  // ------------------------------------------------------------------------
  // Source selection and capture word
  // ------------------------------------------------------------------------
  assign sel_in_range = (32'(sel) < N_SRC);

  // Loop mux instead of a variable part-select so an out-of-range select
  // never indexes past the end of src_flat.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (32'(sel) == k) begin
        sel_word = src_flat[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cap_data = sel_word;
    if (!sel_in_range) begin
      cap_data = (OOR_ZERO != 0) ? '0 : last_q;
    end
  end

  // in_ready comes straight from the skid valid bit so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign sel_err   = err_q;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    last_d      = last_q;
    err_d       = err_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = cap_data;
          main_sel_d  = sel;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_data_d = cap_data;
          main_sel_d  = sel;
        end else if (accept) begin
          skid_data_d = cap_data;
          skid_sel_d  = sel;
          state_d     = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          skid_data_d = '0;
          skid_sel_d  = '0;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything buffered, including a word accepted this cycle.
    if (flush) begin
      state_d     = EMPTY;
      skid_data_d = '0;
      skid_sel_d  = '0;
    end

    // The substitute word for illegal selects tracks legal accepts only.
    if (accept && sel_in_range) begin
      last_d = sel_word;
    end

    // Set has priority over a simultaneous clear.
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept && !sel_in_range) begin
      err_d = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // State and entry registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      last_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_data_source_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for mux_data_source_pipe. Two instances share all inputs: one
// substitutes zero for out-of-range selects, the other the last legal word.
// The reference model is a bounded FIFO (capacity 2) of captured words.
// ---------------------------------------------------------------------------
module tb_mux_data_source_pipe;

  localparam int DATA_W = 32;
  localparam int N_SRC  = 10;
  localparam int SEL_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n;
  logic [DATA_W-1:0]       src [N_SRC];
  logic [N_SRC*DATA_W-1:0] src_flat;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid, out_ready, flush, err_clr;

  logic                    in_ready_z, out_valid_z, sel_err_z;
  logic [DATA_W-1:0]       out_data_z;
  logic [SEL_W-1:0]        out_sel_z;
  logic                    in_ready_h, out_valid_h, sel_err_h;
  logic [DATA_W-1:0]       out_data_h;
  logic [SEL_W-1:0]        out_sel_h;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_flat[g*DATA_W +: DATA_W] = src[g];
  end

  mux_data_source_pipe #(.DATA_W(DATA_W), .N_SRC(N_SRC), .OOR_ZERO(1)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .src_flat(src_flat), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready_z), .out_data(out_data_z),
    .out_sel(out_sel_z), .out_valid(out_valid_z), .out_ready(out_ready),
    .flush(flush), .err_clr(err_clr), .sel_err(sel_err_z));

  mux_data_source_pipe #(.DATA_W(DATA_W), .N_SRC(N_SRC), .OOR_ZERO(0)) u_dut_h (
    .clk(clk), .reset_n(reset_n), .src_flat(src_flat), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready_h), .out_data(out_data_h),
    .out_sel(out_sel_h), .out_valid(out_valid_h), .out_ready(out_ready),
    .flush(flush), .err_clr(err_clr), .sel_err(sel_err_h));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [DATA_W-1:0] m_dz[$];
  logic [DATA_W-1:0] m_dh[$];
  logic [SEL_W-1:0]  m_sel[$];
  logic              m_err;
  logic [DATA_W-1:0] m_last;

  task automatic model_reset();
    m_dz.delete(); m_dh.delete(); m_sel.delete();
    m_err  = 1'b0;
    m_last = '0;
  endtask

  // Advance the model by one edge using the inputs now applied, then clock.
  task automatic step();
    logic legal, acc, dlv;
    logic [DATA_W-1:0] wz, wh;
    legal = (int'(sel) < N_SRC);
    acc   = in_valid && (m_sel.size() < 2);
    dlv   = out_ready && (m_sel.size() > 0);
    if (legal) begin
      wz = src[sel];
      wh = src[sel];
    end else begin
      wz = '0;
      wh = m_last;
    end
    if (acc && legal) m_last = src[sel];
    if (err_clr) m_err = 1'b0;
    if (acc && !legal) m_err = 1'b1;
    if (flush) begin
      m_dz.delete(); m_dh.delete(); m_sel.delete();
    end else begin
      if (dlv) begin
        void'(m_dz.pop_front()); void'(m_dh.pop_front()); void'(m_sel.pop_front());
      end
      if (acc) begin
        m_dz.push_back(wz); m_dh.push_back(wh); m_sel.push_back(sel);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_stream_src();
    for (int k = 0; k < N_SRC; k++) src[k] = 32'hA000_0000 + k;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready_z, out_valid_z, sel_err_z, in_ready_h, out_valid_h, sel_err_h} !== 6'b100100)
      $display("FAIL reset_ctrl: got rdy/vld/err z=%b%b%b h=%b%b%b want 100 100",
               in_ready_z, out_valid_z, sel_err_z, in_ready_h, out_valid_h, sel_err_h);
    else n_pass++;
    n_checks++;
    if (out_data_z !== 32'h0 || out_data_h !== 32'h0 || out_sel_z !== 4'h0)
      $display("FAIL reset_data: got z=%h h=%h sel=%h want 0", out_data_z, out_data_h, out_sel_z);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step();
    n_checks++;
    if (out_valid_z !== 1'b0 || in_ready_z !== 1'b1 || sel_err_z !== 1'b0 || out_data_z !== 32'h0)
      $display("FAIL post_release: got vld=%b rdy=%b err=%b data=%h want 0 1 0 0",
               out_valid_z, in_ready_z, sel_err_z, out_data_z);
    else n_pass++;
  endtask

  task automatic test_streaming();
    set_stream_src();
    out_ready = 1'b1;
    for (int k = 0; k < N_SRC; k++) begin
      in_valid = 1'b1;
      sel      = SEL_W'(k);
      n_checks++;
      if (in_ready_z !== 1'b1) $display("FAIL stream_rdy k=%0d: got %b want 1", k, in_ready_z);
      else n_pass++;
      step();
      n_checks++;
      if (out_valid_z !== 1'b1 || out_data_z !== 32'hA000_0000 + k || out_sel_z !== SEL_W'(k) ||
          out_data_h !== 32'hA000_0000 + k)
        $display("FAIL stream k=%0d: got vld=%b z=%h h=%h sel=%0d want 1 %h", k,
                 out_valid_z, out_data_z, out_data_h, out_sel_z, 32'hA000_0000 + k);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid_z !== 1'b0) $display("FAIL stream_drain: got vld=%b want 0", out_valid_z);
    else n_pass++;
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd3;
    step();
    sel = 4'd7;
    step();
    n_checks++;
    if (in_ready_z !== 1'b0 || in_ready_h !== 1'b0 || out_data_z !== 32'hA000_0003 || out_sel_z !== 4'd3)
      $display("FAIL skid_full: got rdy=%b data=%h sel=%0d want 0 a0000003 3",
               in_ready_z, out_data_z, out_sel_z);
    else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid_z !== 1'b1 || out_data_z !== 32'hA000_0003 || in_ready_z !== 1'b0)
      $display("FAIL skid_hold: got vld=%b data=%h rdy=%b want 1 a0000003 0",
               out_valid_z, out_data_z, in_ready_z);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid_z !== 1'b1 || out_data_z !== 32'hA000_0007 || out_sel_z !== 4'd7 || in_ready_z !== 1'b1)
      $display("FAIL skid_drain: got vld=%b data=%h sel=%0d rdy=%b want 1 a0000007 7 1",
               out_valid_z, out_data_z, out_sel_z, in_ready_z);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid_z !== 1'b0) $display("FAIL skid_empty: got vld=%b want 0", out_valid_z);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 4'd5;
    step();
    sel = 4'd12;
    step();
    n_checks++;
    if (out_data_z !== 32'h0 || out_sel_z !== 4'd12 || sel_err_z !== 1'b1)
      $display("FAIL oor_zero: got data=%h sel=%0d err=%b want 0 12 1", out_data_z, out_sel_z, sel_err_z);
    else n_pass++;
    n_checks++;
    if (out_data_h !== 32'hA000_0005 || out_sel_h !== 4'd12 || sel_err_h !== 1'b1)
      $display("FAIL oor_hold: got data=%h sel=%0d err=%b want a0000005 12 1", out_data_h, out_sel_h, sel_err_h);
    else n_pass++;
    in_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (sel_err_z !== 1'b1 || sel_err_h !== 1'b1)
      $display("FAIL oor_sticky: got err z=%b h=%b want 1", sel_err_z, sel_err_h);
    else n_pass++;
  endtask

  task automatic test_err_clr();
    err_clr  = 1'b1;
    in_valid = 1'b1;
    sel      = 4'd15;
    step();
    n_checks++;
    if (sel_err_z !== 1'b1 || out_sel_z !== 4'd15 || out_data_h !== 32'hA000_0005)
      $display("FAIL err_set_wins: got err=%b sel=%0d h=%h want 1 15 a0000005",
               sel_err_z, out_sel_z, out_data_h);
    else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (sel_err_z !== 1'b0 || sel_err_h !== 1'b0)
      $display("FAIL err_clear: got err z=%b h=%b want 0", sel_err_z, sel_err_h);
    else n_pass++;
    err_clr = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd1;
    step();
    sel = 4'd11;
    step();
    flush = 1'b1;
    sel   = 4'd4;
    step();
    n_checks++;
    if (out_valid_z !== 1'b0 || in_ready_z !== 1'b1 || sel_err_z !== 1'b1 || out_valid_h !== 1'b0)
      $display("FAIL flush_full: got vld=%b rdy=%b err=%b want 0 1 1", out_valid_z, in_ready_z, sel_err_z);
    else n_pass++;
    flush = 1'b0;
    sel   = 4'd2;
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    sel       = 4'd6;
    step();
    n_checks++;
    if (out_valid_z !== 1'b0 || in_ready_z !== 1'b1)
      $display("FAIL flush_accept: got vld=%b rdy=%b want 0 1", out_valid_z, in_ready_z);
    else n_pass++;
    flush    = 1'b0;
    in_valid = 1'b0;
    err_clr  = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd8;
    step();
    sel = 4'd13;
    step();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_z !== 1'b0 || out_valid_h !== 1'b0 || in_ready_z !== 1'b1 ||
        sel_err_z !== 1'b0 || out_data_z !== 32'h0)
      $display("FAIL async_reset: got vld=%b rdy=%b err=%b data=%h want 0 1 0 0",
               out_valid_z, in_ready_z, sel_err_z, out_data_z);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_checks++;
    if (out_valid_z !== 1'b0 || in_ready_z !== 1'b1)
      $display("FAIL async_release: got vld=%b rdy=%b want 0 1", out_valid_z, in_ready_z);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_SRC; k++) src[k] = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) sel = SEL_W'($urandom_range(10, 15));
      else sel = SEL_W'($urandom_range(0, 9));
      flush   = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      n_checks++;
      if (in_ready_z !== (m_sel.size() < 2) || in_ready_h !== (m_sel.size() < 2))
        $display("FAIL rnd_rdy i=%0d: got z=%b h=%b want %b", i, in_ready_z, in_ready_h, m_sel.size() < 2);
      else n_pass++;
      step();
      n_checks++;
      if (out_valid_z !== (m_sel.size() > 0) || out_valid_h !== (m_sel.size() > 0) ||
          sel_err_z !== m_err || sel_err_h !== m_err)
        $display("FAIL rnd_ctrl i=%0d: got vld=%b/%b err=%b/%b want %b %b", i,
                 out_valid_z, out_valid_h, sel_err_z, sel_err_h, m_sel.size() > 0, m_err);
      else n_pass++;
      if (m_sel.size() > 0) begin
        n_checks++;
        if (out_data_z !== m_dz[0] || out_data_h !== m_dh[0] ||
            out_sel_z !== m_sel[0] || out_sel_h !== m_sel[0])
          $display("FAIL rnd_data i=%0d: got z=%h h=%h sel=%0d want %h %h %0d", i,
                   out_data_z, out_data_h, out_sel_z, m_dz[0], m_dh[0], m_sel[0]);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
    for (int k = 0; k < N_SRC; k++) src[k] = '0;
    model_reset();
    test_reset();
    test_streaming();
    test_stall_skid();
    test_out_of_range();
    test_err_clr();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
